// File: rtl/mux_nch_scan.sv
// N-channel registered mux with manual load and round-robin auto-scan.
// Ports: clk, rst_n, ena, mode, load, sel_in, data_in -> y, y_valid, cur_sel, sel_err.
module mux_nch_scan #(
  parameter int WIDTH    = 1,
  parameter int CHANNELS = 4,
  parameter int DWELL    = 8,
  parameter int SELW     = $clog2(CHANNELS)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      ena,
  input  logic                      mode,
  input  logic                      load,
  input  logic [SELW-1:0]           sel_in,
  input  logic [CHANNELS*WIDTH-1:0] data_in,
  output logic [WIDTH-1:0]          y,
  output logic                      y_valid,
  output logic [SELW-1:0]           cur_sel,
  output logic                      sel_err
);

  localparam logic [7:0]      LAST = 8'(DWELL - 1);
  localparam logic [SELW-1:0] TOP  = SELW'(CHANNELS - 1);

  logic [7:0]      cnt_q;
  logic [7:0]      cnt_d;
  logic [SELW-1:0] sel_d;
  logic            mode_q;
  logic            ld_ok;
  logic            wrap;
  logic            chg;
  logic [WIDTH-1:0] ch_data;

  assign ld_ok = load && (int'(sel_in) < CHANNELS);
  assign wrap  = mode && (cnt_q == LAST);
  assign ch_data = data_in[int'(cur_sel)*WIDTH +: WIDTH];

  // load beats scan wrap; terms kept exclusive for unique
  always_comb begin
    sel_d = cur_sel;
    unique case (1'b1)
      ld_ok: sel_d = sel_in;
      (wrap && !ld_ok):
        sel_d = (cur_sel == TOP) ? '0 : cur_sel + 1'b1;
      default: sel_d = cur_sel;
    endcase
  end

  // counter only runs when scan mode was already active last cycle,
  // so a mode change clears it
  always_comb begin
    cnt_d = '0;
    if (!ld_ok && mode && mode_q)
      cnt_d = wrap ? '0 : cnt_q + 8'd1;
  end

  assign chg = (sel_d != cur_sel);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q   <= '0;
      mode_q  <= 1'b0;
      cur_sel <= '0;
      sel_err <= 1'b0;
      y       <= '0;
      y_valid <= 1'b0;
    end else if (ena) begin
      cnt_q   <= cnt_d;
      mode_q  <= mode;
      cur_sel <= sel_d;
      sel_err <= load && !ld_ok;
      y       <= chg ? '0 : ch_data;
      y_valid <= !chg;
    end
  end

endmodule

// File: tb/tb_mux_nch_scan.sv
// Bench for mux_nch_scan: 4-ch and 3-ch instances vs. a reference model.
// Directed plan checks followed by randomized traffic.
module tb_mux_nch_scan;

  localparam int DW = 8;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ena;
  logic        mode;
  logic        load;
  logic [1:0]  sel_in;
  logic [15:0] data_in;

  logic [3:0] y_a, y_b;
  logic       yv_a, yv_b;
  logic [1:0] cs_a, cs_b;
  logic       err_a, err_b;

  always #5 clk = ~clk;

  mux_nch_scan #(.WIDTH(4), .CHANNELS(4), .DWELL(DW)) u_a (
    .clk(clk), .rst_n(rst_n), .ena(ena), .mode(mode),
    .load(load), .sel_in(sel_in), .data_in(data_in),
    .y(y_a), .y_valid(yv_a), .cur_sel(cs_a), .sel_err(err_a)
  );

  mux_nch_scan #(.WIDTH(4), .CHANNELS(3), .DWELL(DW)) u_b (
    .clk(clk), .rst_n(rst_n), .ena(ena), .mode(mode),
    .load(load), .sel_in(sel_in), .data_in(data_in[11:0]),
    .y(y_b), .y_valid(yv_b), .cur_sel(cs_b), .sel_err(err_b)
  );

  int n_cmp = 0;
  int n_bad = 0;

  int m_sel [2];
  int m_cnt [2];
  int m_mq  [2];
  int m_y   [2];
  int m_yv  [2];
  int m_err [2];

  task automatic check(input string tag, input int obs, input int exp);
    n_cmp++;
    if (obs != exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_sel[i] = 0; m_cnt[i] = 0; m_mq[i] = 0;
      m_y[i] = 0; m_yv[i] = 0; m_err[i] = 0;
    end
  endtask

  task automatic model_step();
    for (int i = 0; i < 2; i++) begin
      int nch;
      int dat;
      int ns;
      int nc;
      bit ok;
      nch = (i == 0) ? 4 : 3;
      dat = (i == 0) ? int'(data_in) : int'(data_in[11:0]);
      if (ena) begin
        ok = load && (int'(sel_in) < nch);
        ns = m_sel[i];
        if (ok) ns = int'(sel_in);
        else if (mode && m_cnt[i] == DW - 1) ns = (m_sel[i] + 1) % nch;
        if (ok || !mode || (int'(mode) != m_mq[i])) nc = 0;
        else nc = (m_cnt[i] + 1) % DW;
        m_y[i]   = (ns != m_sel[i]) ? 0 : (dat >> (4 * m_sel[i])) & 15;
        m_yv[i]  = (ns == m_sel[i]) ? 1 : 0;
        m_err[i] = (load && !ok) ? 1 : 0;
        m_mq[i]  = int'(mode);
        m_sel[i] = ns;
        m_cnt[i] = nc;
      end
    end
  endtask

  task automatic compare_all();
    check("a_y", int'(y_a), m_y[0]);
    check("a_yv", int'(yv_a), m_yv[0]);
    check("a_sel", int'(cs_a), m_sel[0]);
    check("a_err", int'(err_a), m_err[0]);
    check("b_y", int'(y_b), m_y[1]);
    check("b_yv", int'(yv_b), m_yv[1]);
    check("b_sel", int'(cs_b), m_sel[1]);
    check("b_err", int'(err_b), m_err[1]);
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    compare_all();
  endtask

  initial begin
    int last;
    int prev;
    int nchg;
    int blanks;
    int guard;
    int hold_sel;
    bit wrapped;

    rst_n = 1'b0; ena = 1'b0; mode = 1'b0; load = 1'b0;
    sel_in = '0; data_in = 16'hA5C3;
    model_reset();
    #1;
    compare_all();
    #11 rst_n = 1'b1;
    ena = 1'b1;

    tick();
    check("plan_y0", int'(y_a), 3);
    check("plan_v0", int'(yv_a), 1);
    check("plan_s0", int'(cs_a), 0);

    load = 1'b1; sel_in = 2'd2;
    tick();
    load = 1'b0;
    check("ld_sel", int'(cs_a), 2);
    check("ld_blank_v", int'(yv_a), 0);
    check("ld_blank_y", int'(y_a), 0);
    tick();
    check("ld_y", int'(y_a), 5);
    check("ld_v", int'(yv_a), 1);
    load = 1'b1;
    tick();
    load = 1'b0;
    check("reload_v", int'(yv_a), 1);

    mode = 1'b1;
    last = -1; nchg = 0; blanks = 0; wrapped = 1'b0;
    prev = int'(cs_a);
    for (int t = 0; t < 40; t++) begin
      tick();
      if (int'(cs_a) != prev) begin
        if (last >= 0) check("dwell_len", t - last, DW);
        if (prev == 3 && cs_a == 2'd0) wrapped = 1'b1;
        last = t;
        nchg++;
      end
      if (!yv_a) blanks++;
      prev = int'(cs_a);
    end
    check("blank_cnt", blanks, nchg);
    check("scan_wrap", int'(wrapped), 1);

    guard = 0;
    while (m_cnt[0] != DW - 1 && guard < 20) begin
      tick();
      guard++;
    end
    check("expiry_found", int'(guard < 20), 1);
    load = 1'b1; sel_in = 2'd1;
    tick();
    load = 1'b0;
    check("exp_ld_sel", int'(cs_a), 1);
    for (int j = 0; j < DW - 1; j++) begin
      tick();
      check("exp_hold", int'(cs_a), 1);
    end
    tick();
    check("exp_adv", int'(cs_a), 2);

    mode = 1'b0;
    tick();
    hold_sel = m_sel[1];
    load = 1'b1; sel_in = 2'd3;
    tick();
    load = 1'b0;
    check("err_pulse", int'(err_b), 1);
    check("err_sel", int'(cs_b), hold_sel);
    check("err_v", int'(yv_b), 1);
    tick();
    check("err_clear", int'(err_b), 0);

    mode = 1'b1;
    repeat (3) tick();
    ena = 1'b0;
    data_in = 16'h1234;
    repeat (5) tick();
    ena = 1'b1;
    data_in = 16'hA5C3;

    guard = 0;
    while (yv_a && guard < 40) begin
      tick();
      guard++;
    end
    check("blank_found", int'(yv_a), 0);
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    compare_all();
    check("rst_y", int'(y_a), 0);
    check("rst_sel", int'(cs_a), 0);
    #2 rst_n = 1'b1;

    for (int r = 0; r < 3000; r++) begin
      ena = ($urandom % 8) != 0;
      if ($urandom % 64 == 0) mode = ~mode;
      load = ($urandom % 6) == 0;
      sel_in = 2'($urandom % 4);
      data_in = 16'($urandom);
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
